// File: rtl/sboom_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR/R) among NREQ burst requesters.
// Optional beat/RLAST/RRESP/RID checking when RD_ARB_LAST_CHECK_EN is defined.
module sboom_rd_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*8-1:0]      req_len,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_last,
  output logic                   busy,
  output logic                   err,
  output logic                   M00_AXI_ARVALID,
  output logic [ADDR_W-1:0]      M00_AXI_ARADDR,
  output logic [ID_W-1:0]        M00_AXI_ARID,
  output logic [7:0]             M00_AXI_ARLEN,
  output logic [2:0]             M00_AXI_ARSIZE,
  output logic [1:0]             M00_AXI_ARBURST,
  output logic                   M00_AXI_ARLOCK,
  output logic [3:0]             M00_AXI_ARCACHE,
  output logic [3:0]             M00_AXI_ARQOS,
  output logic [2:0]             M00_AXI_ARPROT,
  output logic [3:0]             M00_AXI_ARREGION,
  input  logic                   M00_AXI_ARREADY,
  input  logic                   M00_AXI_RVALID,
  input  logic [DATA_W-1:0]      M00_AXI_RDATA,
  input  logic [ID_W-1:0]        M00_AXI_RID,
  input  logic [1:0]             M00_AXI_RRESP,
  input  logic                   M00_AXI_RLAST,
  output logic                   M00_AXI_RREADY
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;

  logic              gnt_found;
  logic [GW-1:0]     gnt_idx;
  logic [GW-1:0]     cand;
  logic [ADDR_W-1:0] addr_sel;
  logic [7:0]        len_sel;
  logic              ar_hs;
  logic              r_hs;

  // Search starts just after the previous winner, so every requester is reached within NREQ grants.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = GW'((32'(last_grant_q) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    addr_sel = '0;
    len_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == GW'(i)) begin
        addr_sel = req_addr[i*ADDR_W +: ADDR_W];
        len_sel  = req_len[i*8 +: 8];
      end
    end
  end

  assign ar_hs = (state_q == ADDR) && M00_AXI_ARREADY;
  assign r_hs  = (state_q == DATA) && M00_AXI_RVALID && rsp_ready[grant_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NREQ - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          grant_d = gnt_idx;
          addr_d  = addr_sel;
          len_d   = len_sel;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) state_d = DATA;
      end
      DATA: begin
        if (r_hs && M00_AXI_RLAST) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = '0;
    rsp_valid        = '0;
    M00_AXI_ARVALID  = 1'b0;
    M00_AXI_RREADY   = 1'b0;
    busy             = (state_q != IDLE);
    if (state_q == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
    if (state_q == ADDR) M00_AXI_ARVALID = 1'b1;
    if (state_q == DATA) begin
      M00_AXI_RREADY     = rsp_ready[grant_q];
      rsp_valid[grant_q] = M00_AXI_RVALID;
    end
    rsp_data         = M00_AXI_RDATA;
    rsp_last         = M00_AXI_RLAST;
    M00_AXI_ARADDR   = addr_q;
    M00_AXI_ARLEN    = len_q;
    M00_AXI_ARID     = ID_W'(grant_q);
    M00_AXI_ARSIZE   = 3'b110;
    M00_AXI_ARBURST  = 2'b01;
    M00_AXI_ARLOCK   = 1'b0;
    M00_AXI_ARCACHE  = '0;
    M00_AXI_ARQOS    = '0;
    M00_AXI_ARPROT   = '0;
    M00_AXI_ARREGION = '0;
  end

`ifdef RD_ARB_LAST_CHECK_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // cnt_q counts beats already accepted, so the last beat must see cnt_q == len_q.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (ar_hs) begin
      cnt_d = '0;
    end else if (r_hs) begin
      cnt_d = cnt_q + 8'd1;
      if ((M00_AXI_RLAST && cnt_q != len_q) || (!M00_AXI_RLAST && cnt_q == len_q) ||
          (M00_AXI_RRESP != 2'b00) || (M00_AXI_RID != ID_W'(grant_q)))
        err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_rsp_fields;
  assign unused_rsp_fields = ^{M00_AXI_RRESP, M00_AXI_RID};
  assign err = 1'b0;
`endif

endmodule
